os_boot_loader: RTL

Startup copy engine that reads the on-chip Genesis OS ROM word by word and writes the image into main work RAM through the memory controller's request/acknowledge port. It sits between the OS ROM and the RAM arbiter. It holds the 68000 in reset until the last word is acknowledged, then releases it. It also produces a 16-bit additive checksum of the copied image for debug readout.

---
 rtl/genesis_boot_pkg.sv | 22 ++
 rtl/os_boot_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/genesis_boot_pkg.sv
// -----------------------------------------------------------------------------
// genesis_boot_pkg
// Shared definitions for the Genesis boot copy engine.
//   boot_state_e      : FSM state encoding (IDLE..DONE, fixed 3-bit values)
//   ROM_LATENCY       : clocks from rom_addr to valid rom_data
//   DEFAULT_DST_BASE  : default byte address of the first RAM destination word
// -----------------------------------------------------------------------------
package genesis_boot_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } boot_state_e;

   localparam int unsigned ROM_LATENCY      = 1;
   localparam logic [23:0] DEFAULT_DST_BASE = 24'h000000;

endpackage

// File: rtl/os_boot_loader.sv
// -----------------------------------------------------------------------------
// os_boot_loader
// Copies WORDS 16-bit words from the OS ROM into work RAM through the arbiter's
// request/acknowledge port, keeps the 68000 in reset until the last word is
// acknowledged, and accumulates a modulo-2^16 checksum of the written words.
//
// Parameters
//   WORDS       : words to copy (1..2048)
//   DST_BASE    : byte address of the first destination word (even)
// Ports
//   clk         : system clock, shared with the ROM
//   rst         : synchronous active-high reset; restarts the copy from word 0
//   rom_addr    : ROM byte address, registered, bit 0 always 0
//   rom_data    : ROM read data, valid one clock after rom_addr
//   ram_req     : write request, held until ram_ack is sampled
//   ram_addr    : destination byte address, stable while ram_req is high
//   ram_wdata   : write data, stable while ram_req is high
//   ram_ack     : one-cycle acceptance pulse; only meaningful in WRITE
//   busy        : copy in progress
//   done        : copy complete, sticky until reset
//   cpu_reset_n : 68000 reset, released together with done
//   checksum    : running sum of acknowledged words
// -----------------------------------------------------------------------------
module os_boot_loader
   import genesis_boot_pkg::*;
#(
   parameter int unsigned WORDS    = 1024,
   parameter logic [23:0] DST_BASE = DEFAULT_DST_BASE
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic        ram_req,
   output logic [23:0] ram_addr,
   output logic [15:0] ram_wdata,
   input  logic        ram_ack,
   output logic        busy,
   output logic        done,
   output logic        cpu_reset_n,
   output logic [15:0] checksum
);

   localparam logic [10:0] LAST_IDX = 11'(WORDS - 1);

   boot_state_e state_q, state_d;
   logic [10:0] idx_q, idx_d;
   logic [11:0] rom_addr_q;
   logic        ram_req_q;
   logic [23:0] ram_addr_q, ram_addr_d;
   logic [15:0] ram_wdata_q, ram_wdata_d;
   logic        busy_q;
   logic        done_q;
   logic [15:0] checksum_q, checksum_d;
   logic        ack_seen;

   // An ack only counts while our own request is actually on the bus.
   assign ack_seen = (state_q == WRITE) && ram_req_q && ram_ack;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      idx_d       = idx_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      checksum_d  = checksum_q;

      unique case (state_q)
         IDLE: begin
            idx_d      = '0;
            checksum_d = '0;
            state_d    = ADDR;
         end
         ADDR: state_d = WAIT;
         WAIT: begin
            // ROM word for idx is valid now; latch it with its destination so
            // both stay frozen for the whole request.
            ram_wdata_d = rom_data;
            ram_addr_d  = DST_BASE + {12'd0, idx_q, 1'b0};
            state_d     = WRITE;
         end
         WRITE: begin
            if (ack_seen) begin
               checksum_d = checksum_q + ram_wdata_q;
               state_d    = NEXT;
            end
         end
         NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 11'd1;
               state_d = ADDR;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         rom_addr_q  <= '0;
         ram_req_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         checksum_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         state_q     <= state_d;
         idx_q       <= idx_d;
         // Registered from the next index so the address is on the ROM pins
         // during the ADDR cycle itself.
         rom_addr_q  <= {idx_d, 1'b0};
         // Outputs are decoded from the next state so they change on the same
         // edge as the state they belong to.
         ram_req_q   <= (state_d == WRITE);
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         busy_q      <= (state_d inside {ADDR, WAIT, WRITE, NEXT});
         done_q      <= (state_d == DONE);
         checksum_q  <= checksum_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign ram_req     = ram_req_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   // The CPU leaves reset on exactly the edge that raises done.
   assign cpu_reset_n = done_q;
   assign checksum    = checksum_q;

endmodule
